// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: arbiter state encoding and default bus widths.
package cpu_pkg;
    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_RESP  = 2'd2;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches upward from i_ptr with wrap and returns the first active request.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    logic [IW-1:0] w_j;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_j      = '0;
        for (int k = 0; k < N; k++) begin
            w_j = IW'((int'(i_ptr) + k) % N);
            if (!o_any && i_req[w_j]) begin
                o_any         = 1'b1;
                o_idx         = w_j;
                o_onehot[w_j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between N_REQ requesters,
// with an optional per-owner lock capped at MAX_HOLD grants under contention.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    lock,
    input  logic [N_REQ-1:0]    we,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]    ack,
    output logic [N_REQ-1:0]    gnt,
    output logic [DW-1:0]       rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    logic [1:0]       r_state;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_rr;
    logic             r_locked;
    logic [HW-1:0]    r_hold;
    logic [N_REQ-1:0] r_gnt;

    logic [N_REQ-1:0] w_own_oh;
    logic             w_others;
    logic             w_keep;
    logic [N_REQ-1:0] w_rr_oh;
    logic [IW-1:0]    w_rr_idx;
    logic             w_rr_any;
    logic [IW-1:0]    w_rr_next;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_rr),
        .o_onehot (w_rr_oh),
        .o_idx    (w_rr_idx),
        .o_any    (w_rr_any)
    );

    assign w_own_oh  = N_REQ'(1) << r_owner;
    assign w_others  = |(req & ~w_own_oh);
    // Lock wins over round-robin until the cap is hit while someone waits.
    assign w_keep    = r_locked && req[r_owner] &&
                       ((r_hold < HOLD_MAX) || !w_others);
    assign w_rr_next = (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + IW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ARB_IDLE;
            r_owner  <= '0;
            r_rr     <= '0;
            r_locked <= 1'b0;
            r_hold   <= '0;
            r_gnt    <= '0;
        end else begin
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_rr_any) begin
                        r_state <= ARB_ISSUE;
                        if (w_keep) begin
                            r_gnt <= w_own_oh;
                            if (r_hold < HOLD_MAX)
                                r_hold <= r_hold + HW'(1);
                        end else begin
                            r_owner <= w_rr_idx;
                            r_gnt   <= w_rr_oh;
                            r_hold  <= HW'(1);
                        end
                    end
                end
                ARB_ISSUE: r_state <= ARB_RESP;
                ARB_RESP: begin
                    r_locked <= lock[r_owner];
                    r_rr     <= w_rr_next;
                    r_state  <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    // Reset gates every output so nothing reaches memory during reset.
    always_comb begin
        ack       = '0;
        gnt       = '0;
        rdata     = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n) begin
            unique case (r_state)
                ARB_ISSUE: begin
                    gnt       = r_gnt;
                    mem_en    = 1'b1;
                    mem_we    = we[r_owner];
                    mem_addr  = addr[int'(r_owner)*AW +: AW];
                    mem_wdata = wdata[int'(r_owner)*DW +: DW];
                end
                ARB_RESP: begin
                    gnt   = r_gnt;
                    ack   = r_gnt;
                    rdata = mem_rdata;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a memory model and an ack scoreboard.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req, lock, we, ack, gnt;
    logic [15:0] addr, wdata;
    logic [7:0]  rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_we;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    typedef struct packed {
        logic [1:0] who;
        logic       wr;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .N_REQ    (2),
        .AW       (8),
        .DW       (8),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .gnt       (gnt),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory with one-cycle registered read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {ack, gnt, mem_en, mem_we, mem_addr, mem_wdata, rdata}, 0);
    endtask

    task automatic push_exp(input int r, input logic w,
                            input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        if (w)
            ref_mem[a] = d;
        e.who  = 2'(1 << r);
        e.wr   = w;
        e.data = w ? 8'h00 : ref_mem[a];
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && ack != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, ack}, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_owner", {30'd0, ack}, {30'd0, mon_e.who});
                if (!mon_e.wr)
                    chk("rdata", {24'd0, rdata}, {24'd0, mon_e.data});
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        chk_idle("reset_out");
    endtask

    // Single access from IDLE; entered and left just after a rising edge.
    task automatic access(input int r, input logic w, input logic [7:0] a,
                          input logic [7:0] d, input string tag);
        logic [1:0] oh;
        oh = 2'(1 << r);
        push_exp(r, w, a, d);
        req[r] = 1'b1;
        we[r]  = w;
        addr[r*8 +: 8]  = a;
        wdata[r*8 +: 8] = d;
        @(negedge clk);
        chk({tag, "_T_gnt"}, gnt, 0);
        chk({tag, "_T_en"}, mem_en, 0);
        @(negedge clk);
        chk({tag, "_T1_en"}, mem_en, 1);
        chk({tag, "_T1_we"}, mem_we, w);
        chk({tag, "_T1_addr"}, mem_addr, a);
        if (w)
            chk({tag, "_T1_wdata"}, mem_wdata, d);
        chk({tag, "_T1_gnt"}, gnt, oh);
        chk({tag, "_T1_ack"}, ack, 0);
        @(negedge clk);
        chk({tag, "_T2_gnt"}, gnt, oh);
        chk({tag, "_T2_ack"}, ack, oh);
        chk({tag, "_T2_en"}, mem_en, 0);
        @(posedge clk);
        #1;
        req[r] = 1'b0;
        we[r]  = 1'b0;
        @(negedge clk);
        chk({tag, "_T3_gnt"}, gnt, 0);
        chk({tag, "_T3_ack"}, ack, 0);
        @(posedge clk);
        #1;
    endtask

    int lock_seq [16] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    logic [1:0] exp_ack;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] <= 8'h00;
            ref_mem[i] = 8'h00;
        end
        mem[5] <= 8'h64;
        ref_mem[5] = 8'h64;

        do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        access(0, 1'b0, 8'h05, 8'h00, "rd05");
        access(1, 1'b1, 8'h10, 8'hA5, "wr10");
        access(1, 1'b0, 8'h10, 8'h00, "rd10");

        // Two requesters held from reset alternate.
        do_reset();
        req = 2'b11;
        addr = {8'h10, 8'h05};
        for (int k = 0; k < 2; k++) begin
            push_exp(0, 1'b0, 8'h05, 8'h00);
            push_exp(1, 1'b0, 8'h10, 8'h00);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp_ack = (i % 3 != 1) ? 2'b00 : (((i / 3) % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr_ack_%0d", i), ack, exp_ack);
        end
        req = 2'b00;
        @(posedge clk);
        #1;

        // Owner 0 locks; cap of 4 applies only while requester 1 waits.
        do_reset();
        req = 2'b11;
        lock = 2'b01;
        addr = {8'h10, 8'h05};
        for (int k = 0; k < 16; k++)
            push_exp(lock_seq[k], 1'b0, (lock_seq[k] == 0) ? 8'h05 : 8'h10, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 48; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp_ack = (i % 3 != 1) ? 2'b00 : 2'(1 << lock_seq[i / 3]);
            chk($sformatf("lock_ack_%0d", i), ack, exp_ack);
            if (i == 29)
                req[1] = 1'b0;
        end
        req = 2'b00;
        lock = 2'b00;
        @(posedge clk);
        #1;

        // Reset during the ISSUE cycle of a write drops it.
        req[0] = 1'b1;
        we[0] = 1'b1;
        addr[7:0] = 8'h20;
        wdata[7:0] = 8'h5A;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req = '0;
        we = '0;
        @(negedge clk);
        chk("rst_mid_strobe", {mem_en, mem_we}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("rst_mid_out");
        chk("rst_mid_mem", mem[8'h20], 8'h00);
        @(posedge clk);
        #1;
        access(0, 1'b0, 8'h20, 8'h00, "rd20");

        // Requester abandons req during ISSUE; ack still comes once.
        push_exp(1, 1'b0, 8'h05, 8'h00);
        req[1] = 1'b1;
        addr[15:8] = 8'h05;
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        @(negedge clk);
        chk("drop_en", mem_en, 1);
        chk("drop_gnt", gnt, 2'b10);
        @(negedge clk);
        chk("drop_ack", ack, 2'b10);
        repeat (2) begin
            @(negedge clk);
            chk_idle("drop_idle");
        end

        @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
